// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage hazard inputs and the stall/bubble/status outputs.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 32
);
   logic [4:0]           d_srcA;
   logic [4:0]           d_srcB;
   logic [4:0]           e_dstM;
   logic                 e_mispredict;
   logic                 e_mdu_start;
   logic                 d_mdu_use;
   logic                 m_mem_req;
   logic                 m_mem_ready;

   logic                 F_stall;
   logic                 D_stall;
   logic                 E_stall;
   logic                 M_stall;
   logic                 D_bubble;
   logic                 E_bubble;
   logic                 M_bubble;
   logic                 W_bubble;
   logic                 mdu_busy;
   logic                 mem_timeout;
   logic [CNT_WIDTH-1:0] stall_cycles;

   // Pipeline side: drives hazard sources, consumes stall/bubble controls.
   modport master (
      output d_srcA, d_srcB, e_dstM, e_mispredict, e_mdu_start, d_mdu_use,
             m_mem_req, m_mem_ready,
      input  F_stall, D_stall, E_stall, M_stall,
             D_bubble, E_bubble, M_bubble, W_bubble,
             mdu_busy, mem_timeout, stall_cycles
   );

   // Controller side.
   modport slave (
      input  d_srcA, d_srcB, e_dstM, e_mispredict, e_mdu_start, d_mdu_use,
             m_mem_req, m_mem_ready,
      output F_stall, D_stall, E_stall, M_stall,
             D_bubble, E_bubble, M_bubble, W_bubble,
             mdu_busy, mem_timeout, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline hazard controller: prioritised stall/bubble generation,
// MDU occupancy tracking, memory wait watchdog and stall-cycle counter.
module pipeline_hazard_ctrl #(
   parameter int unsigned MDU_LATENCY = 4,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   pipeline_hazard_ctrl_if.slave   hz
);

   localparam int unsigned MDU_W  = $clog2(MDU_LATENCY + 1);
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic                 mem_wait_c;
   logic                 load_use_c;
   logic                 mdu_haz_c;

   logic                 f_stall_c, d_stall_c, e_stall_c, m_stall_c;
   logic                 d_bubble_c, e_bubble_c, m_bubble_c, w_bubble_c;

   logic [0:0]           state_q, state_d;
   logic [MDU_W-1:0]     mdu_cnt_q, mdu_cnt_d;
   logic                 mdu_busy_q, mdu_busy_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                 mem_timeout_q, mem_timeout_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // Hazard detection terms.
   always_comb begin
      mem_wait_c = hz.m_mem_req & ~hz.m_mem_ready;
      load_use_c = (hz.e_dstM != 5'd0) &
                   ((hz.e_dstM == hz.d_srcA) | (hz.e_dstM == hz.d_srcB));
      mdu_haz_c  = mdu_busy_q & hz.d_mdu_use;
   end

   // Prioritised stall/bubble selection; reset forces a full flush.
   always_comb begin
      f_stall_c  = 1'b0;
      d_stall_c  = 1'b0;
      e_stall_c  = 1'b0;
      m_stall_c  = 1'b0;
      d_bubble_c = 1'b0;
      e_bubble_c = 1'b0;
      m_bubble_c = 1'b0;
      w_bubble_c = 1'b0;
      if (!reset_n) begin
         d_bubble_c = 1'b1;
         e_bubble_c = 1'b1;
         m_bubble_c = 1'b1;
         w_bubble_c = 1'b1;
      end else if (mem_wait_c) begin
         f_stall_c  = 1'b1;
         d_stall_c  = 1'b1;
         e_stall_c  = 1'b1;
         m_stall_c  = 1'b1;
         w_bubble_c = 1'b1;
      end else if (hz.e_mispredict) begin
         d_bubble_c = 1'b1;
         e_bubble_c = 1'b1;
      end else if (mdu_haz_c || load_use_c) begin
         f_stall_c  = 1'b1;
         d_stall_c  = 1'b1;
         e_bubble_c = 1'b1;
      end
   end

   // Next-state logic for MDU counter, memory FSM, watchdog and perf counter.
   always_comb begin
      mdu_cnt_d     = mdu_cnt_q;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      stall_cnt_d   = stall_cnt_q;

      if (hz.e_mdu_start && !mem_wait_c) begin
         mdu_cnt_d = MDU_W'(MDU_LATENCY);
      end else if (mdu_cnt_q != '0) begin
         mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
      end
      mdu_busy_d = (mdu_cnt_d != '0);

      // A dropped request and a completed access both end the wait.
      if (state_q == ST_IDLE) begin
         if (mem_wait_c) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_W'(1);
         end
      end else begin
         if (mem_wait_c) begin
            if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end else begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      end

      mem_timeout_d = mem_timeout_q |
                      ((state_d == ST_WAIT) && (wait_cnt_d >= WAIT_W'(MEM_TIMEOUT)));

      if (f_stall_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         mdu_cnt_q     <= '0;
         mdu_busy_q    <= 1'b0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         mdu_cnt_q     <= mdu_cnt_d;
         mdu_busy_q    <= mdu_busy_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign hz.F_stall      = f_stall_c;
   assign hz.D_stall      = d_stall_c;
   assign hz.E_stall      = e_stall_c;
   assign hz.M_stall      = m_stall_c;
   assign hz.D_bubble     = d_bubble_c;
   assign hz.E_bubble     = e_bubble_c;
   assign hz.M_bubble     = m_bubble_c;
   assign hz.W_bubble     = w_bubble_c;
   assign hz.mdu_busy     = mdu_busy_q;
   assign hz.mem_timeout  = mem_timeout_q;
   assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MDU_LATENCY=4, MEM_TIMEOUT=5, CNT_WIDTH=5).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MDU_LAT = 4;
   localparam int unsigned MEM_TO  = 5;
   localparam int unsigned CW      = 5;

   localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
   localparam logic [7:0] CTL_LU    = 8'b1100_0100;
   localparam logic [7:0] CTL_MISP  = 8'b0000_1100;
   localparam logic [7:0] CTL_MEM   = 8'b1111_0001;
   localparam logic [7:0] CTL_RESET = 8'b0000_1111;

   logic clock;
   logic reset_n;
   int   total;
   int   bad;
   int   exp_stalls;

   pipeline_hazard_ctrl_if #(.CNT_WIDTH(CW)) hz_if ();

   pipeline_hazard_ctrl #(
      .MDU_LATENCY(MDU_LAT),
      .MEM_TIMEOUT(MEM_TO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .hz     (hz_if)
   );

   // {F,D,E,M stall, D,E,M,W bubble}
   logic [7:0] ctl;
   assign ctl = {hz_if.F_stall, hz_if.D_stall, hz_if.E_stall, hz_if.M_stall,
                 hz_if.D_bubble, hz_if.E_bubble, hz_if.M_bubble, hz_if.W_bubble};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic idle();
      hz_if.d_srcA       = 5'd0;
      hz_if.d_srcB       = 5'd0;
      hz_if.e_dstM       = 5'd0;
      hz_if.e_mispredict = 1'b0;
      hz_if.e_mdu_start  = 1'b0;
      hz_if.d_mdu_use    = 1'b0;
      hz_if.m_mem_req    = 1'b0;
      hz_if.m_mem_ready  = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      #2;
      total++;
      if (ctl !== CTL_RESET) begin
         bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RESET);
      end
      total++;
      if (hz_if.mdu_busy !== 1'b0 || hz_if.mem_timeout !== 1'b0 || hz_if.stall_cycles !== 5'd0) begin
         bad++; $display("FAIL reset_state got busy=%b to=%b cnt=%0d exp 0/0/0",
                         hz_if.mdu_busy, hz_if.mem_timeout, hz_if.stall_cycles);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
      total++;
      if (ctl !== CTL_IDLE) begin
         bad++; $display("FAIL idle_ctl got=%b exp=%b", ctl, CTL_IDLE);
      end
      exp_stalls = 0;
   endtask

   task automatic test_load_use();
      hz_if.e_dstM = 5'd8;
      hz_if.d_srcA = 5'd3;
      hz_if.d_srcB = 5'd8;
      #1;
      total++;
      if (ctl !== CTL_LU) begin
         bad++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, CTL_LU);
      end
      step();
      exp_stalls++;
      hz_if.e_dstM = 5'd0;
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin
         bad++; $display("FAIL load_use_release got=%b exp=%b", ctl, CTL_IDLE);
      end
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL load_use_count got=%0d exp=%0d", hz_if.stall_cycles, exp_stalls);
      end
      hz_if.d_srcA = 5'd0;
      hz_if.d_srcB = 5'd7;
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin
         bad++; $display("FAIL r0_no_hazard got=%b exp=%b", ctl, CTL_IDLE);
      end
      step();
      idle();
   endtask

   task automatic test_mispredict();
      hz_if.e_mispredict = 1'b1;
      hz_if.e_dstM       = 5'd5;
      hz_if.d_srcA       = 5'd5;
      #1;
      total++;
      if (ctl !== CTL_MISP) begin
         bad++; $display("FAIL mispredict_over_lu got=%b exp=%b", ctl, CTL_MISP);
      end
      step();
      idle();
      #1;
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL mispredict_count got=%0d exp=%0d", hz_if.stall_cycles, exp_stalls);
      end
   endtask

   task automatic test_mdu();
      hz_if.e_mdu_start = 1'b1;
      #1;
      total++;
      if (hz_if.mdu_busy !== 1'b0 || ctl !== CTL_IDLE) begin
         bad++; $display("FAIL mdu_start_cycle got busy=%b ctl=%b exp busy=0 ctl=%b",
                         hz_if.mdu_busy, ctl, CTL_IDLE);
      end
      step();
      hz_if.e_mdu_start = 1'b0;
      hz_if.d_mdu_use   = 1'b1;
      for (int i = 0; i < int'(MDU_LAT); i++) begin
         #1;
         total++;
         if (hz_if.mdu_busy !== 1'b1 || ctl !== CTL_LU) begin
            bad++; $display("FAIL mdu_busy_cyc%0d got busy=%b ctl=%b exp busy=1 ctl=%b",
                            i, hz_if.mdu_busy, ctl, CTL_LU);
         end
         step();
         exp_stalls++;
      end
      #1;
      total++;
      if (hz_if.mdu_busy !== 1'b0 || ctl !== CTL_IDLE) begin
         bad++; $display("FAIL mdu_release got busy=%b ctl=%b exp busy=0 ctl=%b",
                         hz_if.mdu_busy, ctl, CTL_IDLE);
      end
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL mdu_count got=%0d exp=%0d", hz_if.stall_cycles, exp_stalls);
      end
      idle();
   endtask

   task automatic test_mem_wait();
      hz_if.m_mem_req    = 1'b1;
      hz_if.m_mem_ready  = 1'b0;
      hz_if.e_mispredict = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ctl !== CTL_MEM) begin
            bad++; $display("FAIL mem_wait_cyc%0d got=%b exp=%b", i, ctl, CTL_MEM);
         end
         step();
         exp_stalls++;
      end
      hz_if.m_mem_ready = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_MISP) begin
         bad++; $display("FAIL mem_ready_misp got=%b exp=%b", ctl, CTL_MISP);
      end
      step();
      idle();
      #1;
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls) || hz_if.mem_timeout !== 1'b0) begin
         bad++; $display("FAIL mem_wait_after got cnt=%0d to=%b exp cnt=%0d to=0",
                         hz_if.stall_cycles, hz_if.mem_timeout, exp_stalls);
      end
   endtask

   task automatic test_timeout();
      hz_if.m_mem_req   = 1'b1;
      hz_if.m_mem_ready = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         #1;
         total++;
         if (hz_if.mem_timeout !== (k > int'(MEM_TO))) begin
            bad++; $display("FAIL timeout_cyc%0d got=%b exp=%b", k, hz_if.mem_timeout, (k > int'(MEM_TO)));
         end
         step();
         exp_stalls++;
      end
      hz_if.m_mem_ready = 1'b1;
      step();
      idle();
      step();
      total++;
      if (hz_if.mem_timeout !== 1'b1) begin
         bad++; $display("FAIL timeout_sticky got=%b exp=1", hz_if.mem_timeout);
      end
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL timeout_count got=%0d exp=%0d", hz_if.stall_cycles, exp_stalls);
      end
   endtask

   task automatic test_async_reset();
      hz_if.e_mdu_start = 1'b1;
      step();
      hz_if.e_mdu_start = 1'b0;
      hz_if.m_mem_req   = 1'b1;
      hz_if.m_mem_ready = 1'b0;
      step();
      step();
      exp_stalls += 2;
      total++;
      if (hz_if.mdu_busy !== 1'b1 || hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL pre_reset got busy=%b cnt=%0d exp busy=1 cnt=%0d",
                         hz_if.mdu_busy, hz_if.stall_cycles, exp_stalls);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_RESET) begin
         bad++; $display("FAIL async_reset_ctl got=%b exp=%b", ctl, CTL_RESET);
      end
      total++;
      if (hz_if.mdu_busy !== 1'b0 || hz_if.stall_cycles !== 5'd0 || hz_if.mem_timeout !== 1'b0) begin
         bad++; $display("FAIL async_reset_state got busy=%b cnt=%0d to=%b exp 0/0/0",
                         hz_if.mdu_busy, hz_if.stall_cycles, hz_if.mem_timeout);
      end
      idle();
      #1;
      reset_n = 1'b1;
      step();
      exp_stalls = 0;
      total++;
      if (hz_if.mdu_busy !== 1'b0 || ctl !== CTL_IDLE) begin
         bad++; $display("FAIL post_reset got busy=%b ctl=%b exp busy=0 ctl=%b",
                         hz_if.mdu_busy, ctl, CTL_IDLE);
      end
   endtask

   task automatic test_req_drop();
      hz_if.m_mem_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         hz_if.m_mem_req = 1'b1;
         repeat (4) begin
            step();
            exp_stalls++;
         end
         hz_if.m_mem_req = 1'b0;
         if (b == 0) step();
      end
      #1;
      total++;
      if (hz_if.mem_timeout !== 1'b0) begin
         bad++; $display("FAIL req_drop_timeout got=%b exp=0", hz_if.mem_timeout);
      end
      idle();
      step();
      total++;
      if (hz_if.stall_cycles !== CW'(exp_stalls)) begin
         bad++; $display("FAIL req_drop_count got=%0d exp=%0d", hz_if.stall_cycles, exp_stalls);
      end
   endtask

   task automatic test_saturate();
      #2;
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      step();
      hz_if.e_dstM = 5'd8;
      hz_if.d_srcA = 5'd8;
      repeat (40) step();
      total++;
      if (ctl !== CTL_LU || hz_if.stall_cycles !== 5'd31) begin
         bad++; $display("FAIL saturate got ctl=%b cnt=%0d exp ctl=%b cnt=31",
                         ctl, hz_if.stall_cycles, CTL_LU);
      end
      idle();
      step();
      total++;
      if (hz_if.stall_cycles !== 5'd31) begin
         bad++; $display("FAIL saturate_hold got=%0d exp=31", hz_if.stall_cycles);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_stalls = 0;
      test_reset();
      test_load_use();
      test_mispredict();
      test_mdu();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      test_req_drop();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the 5-stage MIPS pipeline. Each cycle it produces the stall and bubble controls for the F, D, E, M and W pipeline registers. It resolves four hazard sources: load-use on register-file sources, branch mispredict, occupancy of the multi-cycle mult/div unit (MDU), and data-memory wait states. It also keeps a memory-timeout watchdog and a stall-cycle performance counter.

## Interface
Parameters:
- MDU_LATENCY, 4: number of cycles the MDU stays busy after a start (must be ≥1).
- MEM_TIMEOUT, 255: number of consecutive wait cycles tolerated before `mem_timeout` is raised.
- CNT_WIDTH, 32: width of `stall_cycles`.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_srcA, d_srcB  in  5  register-file sources of the instruction in Decode.
- e_dstM  in  5  load destination of the instruction in Execute; 0 means not a load.
- e_mispredict  in  1  branch in Execute was mispredicted.
- e_mdu_start  in  1  instruction in Execute starts an MDU operation.
- d_mdu_use  in  1  instruction in Decode reads HI/LO or starts an MDU operation.
- m_mem_req  in  1  Memory-stage data access is valid.
- m_mem_ready  in  1  data memory completes the access this cycle.
- F_stall, D_stall, E_stall, M_stall  out  1  hold the corresponding pipeline register.
- D_bubble, E_bubble, M_bubble, W_bubble  out  1  load the bubble value into the corresponding register.
- mdu_busy  out  1  MDU occupied (registered).
- mem_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_WIDTH  count of cycles with F_stall=1; saturates at all-ones.

## Operation
- `mem_wait` = m_mem_req & ~m_mem_ready.
- `load_use` = (e_dstM≠0) & (e_dstM==d_srcA | e_dstM==d_srcB).
- `mdu_haz` = mdu_busy & d_mdu_use.
- Priority, highest first. Exactly one case applies; every unlisted output is 0.
  1. **mem_wait:** F_stall, D_stall, E_stall, M_stall = 1 and W_bubble = 1. The whole front end freezes. Any mispredict or hazard is held and re-evaluated after the wait.
  2. **e_mispredict:** D_bubble = E_bubble = 1, with no stalls. This squashes both wrong-path instructions, and the redirected fetch proceeds. A load_use or mdu_haz on the squashed D instruction is ignored.
  3. **mdu_haz or load_use:** F_stall = D_stall = 1 and E_bubble = 1.
- **MDU counter** (width ceil(log2(MDU_LATENCY+1))), with mdu_busy = (count≠0):
  - If e_mdu_start and not mem_wait, load MDU_LATENCY. A start while already busy reloads the counter.
  - Otherwise, if count≠0, decrement. Decrementing continues during mem_wait.
- **Memory FSM**, states IDLE and WAIT, with a wait counter:
  - IDLE→WAIT on mem_wait; the wait counter loads 1.
  - WAIT stays in WAIT while mem_wait, incrementing the wait counter (saturating).
  - WAIT→IDLE when ~mem_wait.
  - mem_timeout sets when the wait counter reaches MEM_TIMEOUT while in WAIT. It clears only on reset.
  - A request dropped without ready (m_mem_req=0) also returns the FSM to IDLE.
- **stall_cycles:** +1 on every edge where F_stall=1, saturating.

## Timing
- All stall and bubble outputs are combinational from the inputs and registered state, valid in the same cycle. There are no combinational paths between stall/bubble outputs.
- **mdu_busy:** rises on the edge after a sampled start and stays high for exactly MDU_LATENCY cycles. A D-stage MDU user therefore stalls for at most MDU_LATENCY cycles.
- **Load-use:** exactly 1 stall cycle. On the next edge E holds the bubble, so load_use is false.
- **mem_timeout:** asserts on the edge completing wait cycle MEM_TIMEOUT.
- **Reset (reset_n low, async):**
  - State is cleared: MDU count 0, FSM IDLE, wait counter 0, mdu_busy 0, mem_timeout 0, stall_cycles 0.
  - While reset is held, all stalls = 0 and D_bubble, E_bubble, M_bubble, W_bubble = 1, so the pipeline flushes.
  - Deassertion takes effect on the next rising edge.
  - Reset mid-wait or mid-MDU abandons the operation immediately.

## Test plan
- **Load-use:** e_dstM=8, d_srcB=8, other inputs idle. Expect F_stall=D_stall=E_bubble=1 for one cycle and stall_cycles=1. Repeat with e_dstM=0, d_srcA=0: no stall.
- **Mispredict vs load-use:** e_mispredict=1 together with a load_use match. Expect D_bubble=E_bubble=1 and F_stall=0.
- **MDU:** MDU_LATENCY=4. e_mdu_start for 1 cycle, then d_mdu_use held. Expect mdu_busy high for 4 cycles, F_stall high for those 4 cycles, then released.
- **Memory wait:** m_mem_req=1, m_mem_ready low for 3 cycles, with e_mispredict=1 throughout. Expect F/D/E/M_stall and W_bubble high for 3 cycles and no D_bubble during them. D_bubble=E_bubble=1 in the cycle ready rises.
- **Timeout:** MEM_TIMEOUT=5, ready held low for 7 cycles. Expect mem_timeout to rise after the 5th wait cycle and stay high after ready, until reset_n pulses low.
- **Async reset:** assert reset_n low mid-MDU (count=2) and mid-wait, between clock edges. Expect mdu_busy=0, stall_cycles=0 and all bubbles=1 immediately.
